// File: rtl/sevenseg_scan_driver_if.sv
// Purpose: bus between the seven-segment scan driver, the glyph-select
//          logic (sevenseg_control) and the board pins.
// Signals:
//   enable      - 1 = scan display, 0 = dark and frozen
//   digit       - 5-bit glyph code for the current anode_count
//   anode_count - current digit slot index (0..3)
//   an          - anode enables, active-low, an[k] selects slot k
//   seg         - segments, active-low, seg[0]=a .. seg[6]=g
//   dp          - decimal point, active-low (always off)
// Modports: master = scan driver side, slave = controller/pin side.
interface sevenseg_scan_driver_if;
    logic       enable;
    logic [4:0] digit;
    logic [1:0] anode_count;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    modport master (
        input  enable,
        input  digit,
        output anode_count,
        output an,
        output seg,
        output dp
    );

    modport slave (
        output enable,
        output digit,
        input  anode_count,
        input  an,
        input  seg,
        input  dp
    );
endinterface

// File: rtl/sevenseg_scan_driver.sv
// Purpose: time-multiplexed driver for a 4-digit common-anode seven-segment
//          display. It rotates anode_count, samples and decodes the glyph
//          code returned for that slot, and drives active-low anodes and
//          segments. Each slot starts with a blanking interval so that the
//          previous digit's segments never ghost onto the next anode.
// Ports:
//   CLK   - system clock
//   RESET - synchronous, active-high reset
//   bus   - sevenseg_scan_driver_if.master (enable, digit in;
//           anode_count, an, seg, dp out)
// Parameters:
//   REFRESH_DIV  - clock cycles per digit slot (4..2^20)
//   BLANK_CYCLES - all-anodes-off cycles at the start of a slot
//                  (1..REFRESH_DIV-2)
module sevenseg_scan_driver #(
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input  logic                   CLK,
    input  logic                   RESET,
    sevenseg_scan_driver_if.master bus
);

    localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

    localparam logic [3:0] AN_OFF  = 4'hF;
    localparam logic [6:0] SEG_OFF = 7'h7F;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] slot_cnt;
    logic [CNT_W-1:0] slot_next;
    logic [1:0]       anode_cnt;
    logic [1:0]       anode_next;
    logic [3:0]       an_q;
    logic [3:0]       an_next;
    logic [6:0]       seg_q;
    logic [6:0]       seg_next;

    // Glyph code to active-low segment pattern, bit order g..a.
    function automatic logic [6:0] decode(input logic [4:0] code);
        logic [6:0] pat;
        case (code)
            5'd0:    pat = 7'h40;
            5'd1:    pat = 7'h79;
            5'd2:    pat = 7'h24;
            5'd3:    pat = 7'h30;
            5'd4:    pat = 7'h19;
            5'd5:    pat = 7'h12;
            5'd6:    pat = 7'h02;
            5'd7:    pat = 7'h78;
            5'd8:    pat = 7'h00;
            5'd9:    pat = 7'h10;
            5'd10:   pat = 7'h47;  // L
            5'd11:   pat = 7'h4F;  // I
            5'd12:   pat = 7'h2F;  // r
            5'd13:   pat = 7'h40;  // O
            5'd14:   pat = 7'h3F;  // -
            default: pat = SEG_OFF;
        endcase
        return pat;
    endfunction

    // State register together with the slot counter and registered pins.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= ST_BLANK;
            slot_cnt  <= '0;
            anode_cnt <= 2'd0;
            an_q      <= AN_OFF;
            seg_q     <= SEG_OFF;
        end else begin
            state     <= state_next;
            slot_cnt  <= slot_next;
            anode_cnt <= anode_next;
            an_q      <= an_next;
            seg_q     <= seg_next;
        end
    end

    // Next-state: slot timing, slot rotation and blank/show phase.
    always_comb begin
        state_next = state;
        slot_next  = slot_cnt;
        anode_next = anode_cnt;
        if (!bus.enable) begin
            // Freeze rotation but restart the slot so re-enable begins blanked.
            state_next = ST_BLANK;
            slot_next  = '0;
        end else begin
            if (slot_cnt == SLOT_LAST) begin
                slot_next  = '0;
                anode_next = anode_cnt + 2'd1;
            end else begin
                slot_next = slot_cnt + CNT_W'(1);
            end
            case (state)
                ST_BLANK: if (slot_cnt == BLANK_LAST) state_next = ST_SHOW;
                ST_SHOW:  if (slot_cnt == SLOT_LAST)  state_next = ST_BLANK;
                default:  state_next = ST_BLANK;
            endcase
        end
    end

    // Output: next values of the registered anode and segment pins.
    // digit is sampled only on the BLANK->SHOW edge, so it has the whole
    // blank interval to settle and seg stays frozen throughout SHOW.
    always_comb begin
        an_next  = an_q;
        seg_next = seg_q;
        if (!bus.enable) begin
            an_next  = AN_OFF;
            seg_next = SEG_OFF;
        end else if (state == ST_BLANK && state_next == ST_SHOW) begin
            an_next  = ~(4'b0001 << anode_cnt);
            seg_next = decode(bus.digit);
        end else if (state_next == ST_BLANK) begin
            an_next = AN_OFF;
        end
    end

    assign bus.anode_count = anode_cnt;
    assign bus.an          = an_q;
    assign bus.seg         = seg_q;
    assign bus.dp          = 1'b1;

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Directed bench for sevenseg_scan_driver with REFRESH_DIV=8, BLANK_CYCLES=2.
// Inputs change and outputs are sampled on the falling edge of CLK.
module tb_sevenseg_scan_driver;

    logic CLK;
    logic RESET;

    int unsigned n_cmp;
    int unsigned n_err;

    logic       use_table;
    logic [4:0] fixed_digit;

    sevenseg_scan_driver_if bus ();

    sevenseg_scan_driver #(
        .REFRESH_DIV  (8),
        .BLANK_CYCLES (2)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus.master)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Model of sevenseg_control showing "L74I" (LIRO_state=00, num=47).
    function automatic logic [4:0] ctrl_digit(input logic [1:0] idx);
        logic [4:0] d;
        case (idx)
            2'd0:    d = 5'd10;
            2'd1:    d = 5'd7;
            2'd2:    d = 5'd4;
            default: d = 5'd11;
        endcase
        return d;
    endfunction

    always_comb begin
        if (use_table) bus.digit = ctrl_digit(bus.anode_count);
        else           bus.digit = fixed_digit;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // At most one anode may ever be active.
    always @(negedge CLK) begin
        check("an_onehot", 32'($countones(~bus.an) <= 1), 32'd1);
    end

    // Check one full slot, entered at slot_cnt=0. Optionally change the
    // fixed digit at slot_cnt=chg_at (after the sample point).
    task automatic run_slot(input logic [1:0] slot, input logic [3:0] exp_an,
                            input logic [6:0] exp_seg, input int chg_at,
                            input logic [4:0] chg_val);
        for (int c = 0; c < 8; c++) begin
            if (c == chg_at) fixed_digit = chg_val;
            check("slot_idx", 32'(bus.anode_count), 32'(slot));
            if (c < 2) begin
                check("an_blank", 32'(bus.an), 32'hF);
            end else begin
                check("an_show", 32'(bus.an), 32'(exp_an));
                check("seg_show", 32'(bus.seg), 32'(exp_seg));
            end
            tick(1);
        end
    endtask

    initial begin
        n_cmp       = 0;
        n_err       = 0;
        use_table   = 1'b1;
        fixed_digit = 5'd0;
        RESET       = 1'b1;
        bus.enable  = 1'b1;

        // Reset held 3 cycles with enable=1.
        tick(3);
        check("rst_an", 32'(bus.an), 32'hF);
        check("rst_seg", 32'(bus.seg), 32'h7F);
        check("rst_dp", 32'(bus.dp), 32'h1);
        check("rst_idx", 32'(bus.anode_count), 32'h0);
        RESET = 1'b0;
        tick(1);
        check("rel_an1", 32'(bus.an), 32'hF);
        tick(1);
        check("rel_an2", 32'(bus.an), 32'hE);
        check("rel_seg2", 32'(bus.seg), 32'h47);
        tick(6);

        // Rotation with the controller model, wrapping 3 -> 0.
        run_slot(2'd1, 4'hD, 7'h78, -1, 5'd0);
        run_slot(2'd2, 4'hB, 7'h19, -1, 5'd0);
        run_slot(2'd3, 4'h7, 7'h4F, -1, 5'd0);
        run_slot(2'd0, 4'hE, 7'h47, -1, 5'd0);
        run_slot(2'd1, 4'hD, 7'h78, -1, 5'd0);
        run_slot(2'd2, 4'hB, 7'h19, -1, 5'd0);
        run_slot(2'd3, 4'h7, 7'h4F, -1, 5'd0);

        // Sample window: digit 3 -> 8 mid-SHOW of slot 1 is ignored.
        use_table   = 1'b0;
        fixed_digit = 5'd3;
        run_slot(2'd0, 4'hE, 7'h30, -1, 5'd0);
        run_slot(2'd1, 4'hD, 7'h30, 4, 5'd8);
        run_slot(2'd2, 4'hB, 7'h00, -1, 5'd0);
        run_slot(2'd3, 4'h7, 7'h00, -1, 5'd0);
        run_slot(2'd0, 4'hE, 7'h00, -1, 5'd0);
        run_slot(2'd1, 4'hD, 7'h00, -1, 5'd0);

        // Letter glyphs and an out-of-range code.
        run_slot(2'd2, 4'hB, 7'h47, 0, 5'd10);
        run_slot(2'd3, 4'h7, 7'h4F, 0, 5'd11);
        run_slot(2'd0, 4'hE, 7'h2F, 0, 5'd12);
        run_slot(2'd1, 4'hD, 7'h40, 0, 5'd13);
        run_slot(2'd2, 4'hB, 7'h3F, 0, 5'd14);
        run_slot(2'd3, 4'h7, 7'h7F, 0, 5'd20);

        // Enable drop at slot_cnt=5 of slot 2.
        use_table = 1'b1;
        run_slot(2'd0, 4'hE, 7'h47, -1, 5'd0);
        run_slot(2'd1, 4'hD, 7'h78, -1, 5'd0);
        tick(5);
        check("pre_dis_an", 32'(bus.an), 32'hB);
        bus.enable = 1'b0;
        tick(1);
        check("dis_an", 32'(bus.an), 32'hF);
        check("dis_seg", 32'(bus.seg), 32'h7F);
        check("dis_idx", 32'(bus.anode_count), 32'h2);
        tick(1);
        check("dis_an2", 32'(bus.an), 32'hF);
        check("dis_idx2", 32'(bus.anode_count), 32'h2);
        bus.enable = 1'b1;
        tick(1);
        check("reen_blank", 32'(bus.an), 32'hF);
        tick(1);
        check("reen_an", 32'(bus.an), 32'hB);
        check("reen_seg", 32'(bus.seg), 32'h19);
        check("reen_idx", 32'(bus.anode_count), 32'h2);

        // Reset at slot_cnt=6 overrides enable.
        tick(4);
        check("pre_rst_an", 32'(bus.an), 32'hB);
        RESET = 1'b1;
        tick(1);
        check("mid_rst_idx", 32'(bus.anode_count), 32'h0);
        check("mid_rst_an", 32'(bus.an), 32'hF);
        check("mid_rst_seg", 32'(bus.seg), 32'h7F);
        RESET = 1'b0;
        tick(1);
        check("post_rst_an1", 32'(bus.an), 32'hF);
        tick(1);
        check("post_rst_an2", 32'(bus.an), 32'hE);
        check("post_rst_seg", 32'(bus.seg), 32'h47);
        check("dp_off", 32'(bus.dp), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
